// File: rtl/block_beat_counter.sv
// Beat counter for one channel-coder code block, with a start handshake, a latched block size,
// a last-beat flag and a done pulse. Optional frame counter: define BLKCNT_FRAME_CNT_EN.
module block_beat_counter #(
   parameter int unsigned CNT_W      = 13,
   parameter int unsigned STEP       = 8,
   parameter int unsigned SMALL_SIZE = 1056,
   parameter int unsigned LARGE_SIZE = 6144
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             block_size,
   input  logic             count_enable,
   input  logic             abort,
   output logic [CNT_W-1:0] count,
   output logic             last_beat,
   output logic             target_reached,
   output logic             busy,
   output logic             done,
   output logic             size_latched
`ifdef BLKCNT_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_count
`endif
);

   localparam int unsigned BIDX_W = $clog2(LARGE_SIZE / STEP);
   localparam logic [BIDX_W-1:0] LAST_SMALL = BIDX_W'(SMALL_SIZE / STEP - 1);
   localparam logic [BIDX_W-1:0] LAST_LARGE = BIDX_W'(LARGE_SIZE / STEP - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StCount = 2'b01,
      StDone  = 2'b10
   } state_e;

   state_e            state_q, state_d;
   logic [BIDX_W-1:0] beat_q, beat_d;
   logic              size_q, size_d;
   logic              done_q, done_d;
   logic [BIDX_W-1:0] last_idx;
   logic              at_last;

   assign last_idx = size_q ? LAST_LARGE : LAST_SMALL;
   assign at_last  = (state_q == StCount) && (beat_q == last_idx);

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      size_d  = size_q;
      done_d  = 1'b0;
      if (abort) begin
         // Abort overrides start and the last beat; the size latch is left alone.
         state_d = StIdle;
         beat_d  = '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_d = StCount;
                  beat_d  = '0;
                  size_d  = block_size;
               end
            end
            StCount: begin
               if (count_enable) begin
                  if (at_last) begin
                     state_d = StDone;
                     done_d  = 1'b1;
                  end else begin
                     beat_d = beat_q + BIDX_W'(1);
                  end
               end
            end
            default: begin
               state_d = StIdle;
               beat_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         beat_q  <= '0;
         size_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         size_q  <= size_d;
         done_q  <= done_d;
      end
   end

`ifdef BLKCNT_FRAME_CNT_EN
   logic [15:0] frame_q;

   // Advances on the same edge that raises done, so both are visible together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_q <= '0;
      end else if (done_d) begin
         frame_q <= frame_q + 16'd1;
      end
   end

   assign frame_count = frame_q;
`endif

   assign count          = CNT_W'(beat_q) * CNT_W'(STEP);
   assign last_beat      = at_last;
   assign target_reached = (state_q == StDone);
   assign busy           = (state_q == StCount);
   assign done           = done_q;
   assign size_latched   = size_q;

endmodule

// File: doc/block_beat_counter.md
Name: block_beat_counter

Overview:
- Parametrised successor to the fixed two-size block counter in the channel coder input path.
- Counts accepted data beats of STEP bits each across one code block of selectable size. Small and large block sizes are parameters.
- Provides an explicit start handshake, a latched size selection, a last-beat indication, a registered done pulse and a synchronous abort.
- Sits between the input interface and the block buffer write-address logic; drives buffer write address and end-of-block control.

Parameters:
- CNT_W, 13, width of count output; must hold LARGE_SIZE.
- STEP, 8, bits per beat; count advances by STEP per accepted beat.
- SMALL_SIZE, 1056, block length in bits when size_sel=0; multiple of STEP.
- LARGE_SIZE, 6144, block length in bits when size_sel=1; multiple of STEP.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a new block; accepted in IDLE or DONE only
- block_size  input  1  0 = small, 1 = large; sampled on the accepted start
- count_enable  input  1  one beat accepted this cycle (ignored unless in COUNT)
- abort  input  1  synchronous return to IDLE; priority over start and count_enable
- count  output  CNT_W  bit offset of current beat = beat_index*STEP
- last_beat  output  1  combinational; high in COUNT when beat_index = N-1
- target_reached  output  1  high in DONE state
- busy  output  1  high in COUNT state
- done  output  1  one-cycle registered pulse on entry to DONE
- size_latched  output  1  block_size captured at the last accepted start

Behaviour:
- N = SIZE/STEP beats per block: 132 (small) or 768 (large) at defaults. The beat index is ceil(log2(LARGE_SIZE/STEP)) bits wide.
- Reset (async, active-high) values: state=IDLE, beat_index=0, count=0, last_beat=0, target_reached=0, busy=0, done=0, size_latched=0.
- States: IDLE, COUNT, DONE.
- IDLE:
  - start=1 -> COUNT next cycle, with beat_index=0 and size_latched=block_size.
  - count_enable is ignored.
- COUNT:
  - count_enable=1 and beat_index<N-1 -> beat_index+1 next cycle.
  - count_enable=1 and beat_index=N-1 (last_beat=1) -> DONE next cycle; beat_index holds N-1; done=1 for that one cycle.
  - count_enable=0 -> hold.
  - start is ignored.
- DONE:
  - target_reached=1; count holds SIZE-STEP (1048 small, 6136 large); count_enable is ignored.
  - start=1 -> COUNT with beat_index=0 and a new size latch. Back-to-back blocks therefore have one DONE cycle between them.
- abort=1 in any state -> IDLE next cycle with beat_index=0. No done pulse; a done already in flight still completes its single cycle.
- Simultaneous events:
  - abort with start: abort wins.
  - last beat with abort: abort wins; DONE is not entered.
- Changes to block_size after the accepted start have no effect until the next start.
- count = beat_index*STEP, zero-extended to CNT_W. No wrap-around is possible within a block.
- Latency: count_enable at cycle t updates count at t+1. done is asserted at t+1 after the last beat at t.

Optional Feature:
- Macro: BLKCNT_FRAME_CNT_EN.
- With the macro defined: extra output frame_count [15:0], reset to 0. It increments by 1 on every done pulse and wraps from 65535 to 0. abort does not clear it.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-COUNT: set beat_index=50, then pulse reset asynchronously -> all outputs 0 immediately, state IDLE.
- Small block: start with block_size=0, then 132 consecutive count_enable -> count steps 0,8,...,1048; last_beat high at count=1048; done high for exactly 1 cycle; target_reached=1; busy=0.
- Large block with gaps: start with block_size=1, then 768 enables with random idle cycles; toggle block_size mid-block -> size_latched stays 1; done after 768 enables with count=6136.
- Abort at last beat: in small block at beat 131, assert count_enable and abort together -> IDLE, count=0, no done.
- Back-to-back: start during DONE with block_size=0 -> COUNT next cycle with count=0; start asserted during COUNT is ignored (count continues, no reset).
- With BLKCNT_FRAME_CNT_EN: run 3 blocks plus 1 aborted block -> frame_count=3; force 65535 then complete a block -> 0.
